// File: rtl/btn_event_display_pkg.sv
// Shared layout constants for the packed button/event display word.
package btn_event_display_pkg;

  localparam int DATA_W       = 128;
  localparam int STATE_LSB    = 0;
  localparam int LAST_IDX_LSB = 28;
  localparam int PCNT_LSB     = 64;
  localparam int SEQ_LSB      = 120;
  localparam int PCNT_W       = 8;
  localparam int SEQ_W        = 8;
  localparam int MAX_BUTTONS  = 7;

  // Value of the last-pressed index field before any press has been seen.
  localparam logic [3:0] IDX_NONE = 4'hF;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, polarity fix, debounce, rise strobe.
module btn_debounce_ch #(
  parameter int C_debounce_bits = 16,
  parameter bit C_invert_bit    = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pressed,
  output logic press_strobe
);

  logic                       sync0;
  logic                       sync1;
  logic                       pressed_d;
  logic [C_debounce_bits-1:0] cnt;
  logic                       s;

  // Sync flops reset to 0, so an active-low input reads as "pressed" until
  // the synchroniser has filled; the debounce window absorbs that glitch.
  assign s = sync1 ^ C_invert_bit;

  // Synchronise, debounce (toggle after 2**N consecutive mismatches), strobe on rise.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0        <= 1'b0;
      sync1        <= 1'b0;
      pressed      <= 1'b0;
      pressed_d    <= 1'b0;
      press_strobe <= 1'b0;
      cnt          <= '0;
    end else begin
      sync0        <= btn;
      sync1        <= sync0;
      pressed_d    <= pressed;
      press_strobe <= pressed & ~pressed_d;
      if (s == pressed) begin
        cnt <= '0;
      end else if (&cnt) begin
        pressed <= s;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_event_display.sv
// Debounced buttons, press counters and last-press index packed into a
// 128-bit word for the hex display decoder.
module btn_event_display
  import btn_event_display_pkg::*;
#(
  parameter int         C_buttons       = 7,
  parameter logic [6:0] C_invert        = 7'b0000001,
  parameter int         C_debounce_bits = 16,
  parameter int         C_count_bits    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [C_buttons-1:0] btn,
  output logic [C_buttons-1:0] pressed,
  output logic [C_buttons-1:0] press_strobe,
  output logic                 update,
  output logic [DATA_W-1:0]    data
);

  logic [C_count_bits-1:0] pcnt   [C_buttons];
  logic [C_count_bits-1:0] pcnt_n [C_buttons];
  logic [SEQ_W-1:0]        seq;
  logic [SEQ_W-1:0]        seq_n;
  logic [3:0]              last_idx;
  logic [3:0]              last_n;
  logic [DATA_W-1:0]       data_n;

  for (genvar i = 0; i < C_buttons; i++) begin : g_ch
    btn_debounce_ch #(
      .C_debounce_bits(C_debounce_bits),
      .C_invert_bit   (C_invert[i])
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .btn         (btn[i]),
      .pressed     (pressed[i]),
      .press_strobe(press_strobe[i])
    );
  end

  // Next counters, priority-encoded last index (highest wins) and packed word.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pcnt_n = pcnt;
    seq_n  = seq;
    last_n = last_idx;
    for (int i = 0; i < C_buttons; i++) begin
      if (press_strobe[i]) begin
        pcnt_n[i] = pcnt[i] + 1'b1;
        last_n    = 4'(i);
      end
    end
    if (|press_strobe) seq_n = seq + 1'b1;

    data_n                          = '0;
    data_n[LAST_IDX_LSB +: 4]       = last_n;
    data_n[SEQ_LSB +: SEQ_W]        = seq_n;
    for (int i = 0; i < C_buttons; i++) begin
      data_n[STATE_LSB + 4*i]             = pressed[i];
      data_n[PCNT_LSB + PCNT_W*i +: PCNT_W] = PCNT_W'(pcnt_n[i]);
    end
  end

  // Register counters and the display word; flag any change of the word.
  // NOTE: the counter array is a handful of flops, not a RAM, so it is reset like any register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < C_buttons; i++) pcnt[i] <= '0;
      seq                       <= '0;
      last_idx                  <= IDX_NONE;
      data                      <= '0;
      data[LAST_IDX_LSB +: 4]   <= IDX_NONE;
      update                    <= 1'b0;
    end else begin
      pcnt     <= pcnt_n;
      seq      <= seq_n;
      last_idx <= last_n;
      data     <= data_n;
      update   <= (data_n != data);
    end
  end

endmodule

// File: tb/tb_btn_event_display.sv
// Bench for btn_event_display: behavioural model plus directed and random stimulus.
module tb_btn_event_display;

  localparam int         NB  = 7;
  localparam int         DB  = 4;
  localparam int         WIN = 1 << DB;
  localparam logic [6:0] INV = 7'b0000001;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] btn = 7'b0000001;
  logic [NB-1:0] pressed;
  logic [NB-1:0] press_strobe;
  logic          update;
  logic [127:0]  data;

  logic [127:0]  rst_data;
  int            n_checks = 0;
  int            n_err    = 0;
  bit            chk_en   = 1'b0;
  int            hold [NB];

  btn_event_display #(
    .C_buttons      (NB),
    .C_invert       (INV),
    .C_debounce_bits(DB),
    .C_count_bits   (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn         (btn),
    .pressed     (pressed),
    .press_strobe(press_strobe),
    .update      (update),
    .data        (data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  // Inputs are seen two clocks late; a button's state flips once it has
  // disagreed with its polarity-corrected input for WIN cycles in a row.
  // Counters, seq and last index react to last cycle's strobes; the word
  // shows last cycle's pressed state.
  logic [NB-1:0] m_dly1, m_dly2, m_prs, m_prs_d, m_strobe;
  int            m_run  [NB];
  int            m_pcnt [NB];
  int            m_seq, m_last;
  logic [127:0]  m_data;
  logic          m_upd;

  always @(posedge clk or posedge reset) begin : model
    logic [NB-1:0] seen;
    logic [127:0]  d;
    if (reset) begin
      m_dly1 = '0; m_dly2 = '0; m_prs = '0; m_prs_d = '0; m_strobe = '0;
      for (int i = 0; i < NB; i++) begin m_run[i] = 0; m_pcnt[i] = 0; end
      m_seq  = 0;
      m_last = 15;
      m_data = 128'hF << 28;
      m_upd  = 1'b0;
    end else begin
      seen = m_dly2 ^ INV;
      for (int i = 0; i < NB; i++)
        if (m_strobe[i]) begin m_pcnt[i] = (m_pcnt[i] + 1) % 256; m_last = i; end
      if (m_strobe != 0) m_seq = (m_seq + 1) % 256;
      d = '0;
      for (int i = 0; i < NB; i++) begin
        d[4*i]         = m_prs[i];
        d[64+8*i +: 8] = m_pcnt[i][7:0];
      end
      d[28 +: 4]  = m_last[3:0];
      d[120 +: 8] = m_seq[7:0];
      m_upd    = (d != m_data);
      m_data   = d;
      m_strobe = m_prs & ~m_prs_d;
      m_prs_d  = m_prs;
      for (int i = 0; i < NB; i++) begin
        if (seen[i] != m_prs[i]) begin
          m_run[i]++;
          if (m_run[i] == WIN) begin m_prs[i] = seen[i]; m_run[i] = 0; end
        end else begin
          m_run[i] = 0;
        end
      end
      m_dly2 = m_dly1;
      m_dly1 = btn;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pressed", {121'b0, pressed}, {121'b0, m_prs});
      check("strobe",  {121'b0, press_strobe}, {121'b0, m_strobe});
      check("update",  {127'b0, update}, {127'b0, m_upd});
      check("data",    data, m_data);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_data = 128'hF << 28;
    step(3);
    chk_en = 1'b1;
    check("rst_pressed", {121'b0, pressed}, 128'h0);
    check("rst_data", data, rst_data);
    check("rst_update", {127'b0, update}, 128'h0);
    reset = 1'b0;
    step(5);

    // Clean press on btn[3]
    btn[3] = 1'b1;
    step(17); check("p3_early", {127'b0, pressed[3]}, 128'h0);
    step(1);  check("p3_rise", {127'b0, pressed[3]}, 128'h1);
              check("s3_not_yet", {127'b0, press_strobe[3]}, 128'h0);
    step(1);  check("s3_pulse", {127'b0, press_strobe[3]}, 128'h1);
              check("d12", {127'b0, data[12]}, 128'h1);
    step(1);  check("s3_gone", {127'b0, press_strobe[3]}, 128'h0);
              check("last3", {124'b0, data[31:28]}, 128'h3);
              check("pcnt3", {120'b0, data[95:88]}, 128'h1);
              check("seq1", {120'b0, data[127:120]}, 128'h1);
              check("upd_press", {127'b0, update}, 128'h1);
    btn[3] = 1'b0;
    step(25);

    // Asynchronous reset mid-cycle
    #2 reset = 1'b1;
    #1;
    check("arst_pressed", {121'b0, pressed}, 128'h0);
    check("arst_strobe", {121'b0, press_strobe}, 128'h0);
    check("arst_data", data, rst_data);
    check("arst_update", {127'b0, update}, 128'h0);
    @(posedge clk); #1 reset = 1'b0;
    step(5);

    // Bounce rejection on btn[2]
    for (int k = 0; k < 16; k++) begin
      btn[2] = 1'b1; step(10);
      check("bounce_hi", {126'b0, pressed[2], update}, 128'h0);
      btn[2] = 1'b0; step(3);
      check("bounce_lo", {126'b0, pressed[2], update}, 128'h0);
    end
    step(20);

    // Inverted input btn[0]
    btn[0] = 1'b0;
    step(18); check("p0_rise", {127'b0, pressed[0]}, 128'h1);
    step(1);  check("s0_pulse", {127'b0, press_strobe[0]}, 128'h1);
    step(1);  check("d0", {127'b0, data[0]}, 128'h1);
              check("pcnt0", {120'b0, data[71:64]}, 128'h1);
    btn[0] = 1'b1;
    step(18); check("p0_fall", {127'b0, pressed[0]}, 128'h0);
    step(1);  check("s0_release", {127'b0, press_strobe[0]}, 128'h0);
    step(5);

    // Simultaneous press of btn[1] and btn[5]
    btn[1] = 1'b1; btn[5] = 1'b1;
    step(19); check("s15", {121'b0, press_strobe}, 128'h22);
    step(1);  check("last5", {124'b0, data[31:28]}, 128'h5);
              check("seq2", {120'b0, data[127:120]}, 128'h2);
              check("pcnt1", {120'b0, data[79:72]}, 128'h1);
              check("pcnt5", {120'b0, data[111:104]}, 128'h1);
    btn[1] = 1'b0; btn[5] = 1'b0;
    step(20);

    // Counter wrap: 255 more presses of btn[1]
    for (int k = 0; k < 255; k++) begin
      btn[1] = 1'b1; step(20);
      btn[1] = 1'b0; step(20);
    end
    check("pcnt1_wrap", {120'b0, data[79:72]}, 128'h0);
    step(5);

    // Reset during debounce of btn[4]
    btn[4] = 1'b1;
    step(10);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(17); check("p4_early", {127'b0, pressed[4]}, 128'h0);
    step(1);  check("p4_rise", {127'b0, pressed[4]}, 128'h1);
    step(2);  check("pcnt4", {120'b0, data[103:96]}, 128'h1);
    btn[4] = 1'b0;
    step(25);

    // Randomized hold times on every button
    for (int i = 0; i < NB; i++) hold[i] = $urandom_range(1, 40);
    repeat (3000) begin
      for (int i = 0; i < NB; i++) begin
        if (hold[i] == 0) begin
          btn[i]  = ~btn[i];
          hold[i] = $urandom_range(1, 40);
        end else begin
          hold[i]--;
        end
      end
      step(1);
    end
    btn = 7'b0000001;
    step(30);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
